// File: rtl/arilla_bus_arbiter_pkg.sv
// arilla_pkg: shared widths, response record and hit helper for the arilla bus arbiter.
package arilla_pkg;

  localparam int ARILLA_DATA_WIDTH     = 32;
  localparam int ARILLA_ADDR_WIDTH     = 32;
  localparam int ARILLA_BYTES_PER_WORD = ARILLA_DATA_WIDTH / 8;
  // Wide enough to encode up to 8 masters.
  localparam int ARILLA_ID_WIDTH       = 3;

  // One outstanding response: issued in the grant cycle, presented one cycle later.
  typedef struct packed {
    logic                       valid;
    logic [ARILLA_ID_WIDTH-1:0] id;
    logic                       err;
    logic                       is_read;
  } arilla_rsp_t;

  // Slaves drive hit as tri-state; only a solid 1 counts as a hit, z/x is a miss.
  function automatic logic arilla_hit_f(input logic hit);
    return (hit === 1'b1);
  endfunction

endpackage

// File: rtl/arilla_bus_arbiter_if.sv
// arilla_bus_if: shared arilla bus segment. The master side drives the request,
// slaves return hit/data_ptc as tri-state nets.
interface arilla_bus_if
  import arilla_pkg::*;
  ;

  logic [ARILLA_ADDR_WIDTH-1:0]     address;
  logic [ARILLA_BYTES_PER_WORD-1:0] byte_enable;
  logic [ARILLA_DATA_WIDTH-1:0]     data_ctp;
  logic                             read;
  logic                             write;
  logic                             intercept;
  wire                              hit;
  wire  [ARILLA_DATA_WIDTH-1:0]     data_ptc;

  modport master (
    output address, byte_enable, data_ctp, read, write,
    input  hit, data_ptc
  );

  modport slave (
    input  address, byte_enable, data_ctp, read, write,
    output hit, data_ptc, intercept
  );

endinterface

// File: rtl/arilla_bus_arbiter_rr_pick.sv
// arilla_rr_pick: combinational round-robin picker. Searches upward from last+1
// (mod N) and returns the first asserted request as one-hot and encoded index.
module arilla_rr_pick
  import arilla_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]               req,
  input  logic [ARILLA_ID_WIDTH-1:0] last,
  output logic [N-1:0]               gnt,
  output logic [ARILLA_ID_WIDTH-1:0] idx,
  output logic                       any
);

  // Walk the N positions after last in rotating order; the first requester wins.
  always_comb begin : pick_p
    int cand;
    cand = 0;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last) + i) % N;
      for (int j = 0; j < N; j++) begin
        if (!any && req[j] && (j == cand)) begin
          any    = 1'b1;
          idx    = ARILLA_ID_WIDTH'(j);
          gnt[j] = 1'b1;
        end else begin
          any = any;
        end
      end
    end
  end

endmodule

// File: rtl/arilla_bus_arbiter.sv
// arilla_bus_arbiter: round-robin arbiter for one arilla bus segment with
// per-master lock and one-cycle response routing.
// Optional feature macro: ARILLA_ARB_DECODE_ERR_EN (decode error from !hit).
module arilla_bus_arbiter
  import arilla_pkg::*;
#(
  parameter int NumMasters = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  arilla_bus_if.master                           bus_interface,
  input  logic [NumMasters-1:0]                  m_req,
  input  logic [NumMasters-1:0]                  m_we,
  input  logic [NumMasters-1:0]                  m_lock,
  input  logic [NumMasters*ARILLA_ADDR_WIDTH-1:0] m_addr,
  input  logic [NumMasters*ARILLA_BYTES_PER_WORD-1:0] m_be,
  input  logic [NumMasters*ARILLA_DATA_WIDTH-1:0] m_wdata,
  output logic [NumMasters-1:0]                  m_gnt,
  output logic [NumMasters-1:0]                  m_rsp_valid,
  output logic                                   m_rsp_err,
  output logic [ARILLA_DATA_WIDTH-1:0]           m_rsp_rdata
);

  localparam int AW = ARILLA_ADDR_WIDTH;
  localparam int DW = ARILLA_DATA_WIDTH;
  localparam int BW = ARILLA_BYTES_PER_WORD;
  localparam int IW = ARILLA_ID_WIDTH;

  logic [NumMasters-1:0] owner_mask_s;
  logic [NumMasters-1:0] req_eff_s;
  logic [NumMasters-1:0] pick_gnt_s;
  logic [NumMasters-1:0] gnt_s;
  logic [IW-1:0]         pick_idx_s;
  logic                  pick_any_s;
  logic                  any_s;
  logic                  lock_hold_s;
  logic                  we_w_s;
  logic                  lock_w_s;
  logic [AW-1:0]         addr_w_s;
  logic [BW-1:0]         be_w_s;
  logic [DW-1:0]         wdata_w_s;
  logic                  rd_ok_s;
`ifdef ARILLA_ARB_DECODE_ERR_EN
  logic                  hit_s;
`else
  logic                  unused_s;
`endif

  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic                  locked_q, locked_d;
  arilla_rsp_t           rsp_q, rsp_d;

  // While the owner keeps its lock asserted, hide every other request from the picker.
  always_comb begin
    owner_mask_s = '0;
    for (int i = 0; i < NumMasters; i++) begin
      owner_mask_s[i] = (owner_q == IW'(i));
    end
    lock_hold_s = locked_q & (|(m_lock & owner_mask_s));
    if (lock_hold_s) begin
      req_eff_s = m_req & owner_mask_s;
    end else begin
      req_eff_s = m_req;
    end
  end

  arilla_rr_pick #(
    .N (NumMasters)
  ) u_pick (
    .req  (req_eff_s),
    .last (last_q),
    .gnt  (pick_gnt_s),
    .idx  (pick_idx_s),
    .any  (pick_any_s)
  );

  // Gate the grant with reset and mux the winner's payload onto the bus (zero when idle).
  always_comb begin
    gnt_s     = pick_gnt_s & {NumMasters{rst_n}};
    any_s     = pick_any_s & rst_n;
    we_w_s    = 1'b0;
    lock_w_s  = 1'b0;
    addr_w_s  = '0;
    be_w_s    = '0;
    wdata_w_s = '0;
    for (int i = 0; i < NumMasters; i++) begin
      we_w_s    = we_w_s    | (m_we[i] & gnt_s[i]);
      lock_w_s  = lock_w_s  | (m_lock[i] & gnt_s[i]);
      addr_w_s  = addr_w_s  | (m_addr[i*AW +: AW]  & {AW{gnt_s[i]}});
      be_w_s    = be_w_s    | (m_be[i*BW +: BW]    & {BW{gnt_s[i]}});
      wdata_w_s = wdata_w_s | (m_wdata[i*DW +: DW] & {DW{gnt_s[i]}});
    end
    m_gnt                     = gnt_s;
    bus_interface.read        = any_s & ~we_w_s;
    bus_interface.write       = any_s & we_w_s;
    bus_interface.address     = addr_w_s;
    bus_interface.byte_enable = be_w_s;
    bus_interface.data_ctp    = wdata_w_s;
  end

  // Next state: advance the round-robin pointer, capture the response, track lock ownership.
  always_comb begin
`ifdef ARILLA_ARB_DECODE_ERR_EN
    hit_s    = arilla_hit_f(bus_interface.hit);
`endif
    last_d   = last_q;
    owner_d  = owner_q;
    locked_d = lock_hold_s;
    rsp_d    = '0;
    if (any_s) begin
      last_d        = pick_idx_s;
      rsp_d.valid   = 1'b1;
      rsp_d.id      = pick_idx_s;
      rsp_d.is_read = ~we_w_s;
`ifdef ARILLA_ARB_DECODE_ERR_EN
      rsp_d.err     = ~hit_s;
`else
      rsp_d.err     = 1'b0;
`endif
      if (lock_w_s) begin
        owner_d  = pick_idx_s;
        locked_d = 1'b1;
      end else begin
        locked_d = 1'b0;
      end
    end else begin
      rsp_d = '0;
    end
  end

  // State registers; reset drops any pending response and makes master 0 win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= IW'(NumMasters - 1);
      owner_q  <= '0;
      locked_q <= 1'b0;
      rsp_q    <= '0;
    end else begin
      last_q   <= last_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      rsp_q    <= rsp_d;
    end
  end

  // Response cycle: strobe the issuing master and pass read data straight through.
  always_comb begin
    for (int i = 0; i < NumMasters; i++) begin
      m_rsp_valid[i] = rsp_q.valid & (rsp_q.id == IW'(i));
    end
`ifdef ARILLA_ARB_DECODE_ERR_EN
    m_rsp_err = rsp_q.valid & rsp_q.err;
    rd_ok_s   = rsp_q.valid & rsp_q.is_read & ~rsp_q.err;
`else
    m_rsp_err = 1'b0;
    rd_ok_s   = rsp_q.valid & rsp_q.is_read;
`endif
    if (rd_ok_s) begin
      m_rsp_rdata = bus_interface.data_ptc;
    end else begin
      m_rsp_rdata = '0;
    end
  end

`ifndef ARILLA_ARB_DECODE_ERR_EN
  // Without decode errors the hit line and the captured err bit carry no meaning.
  assign unused_s = ^{rsp_q.err, bus_interface.hit};
`endif

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// tb_arilla_bus_arbiter: directed, table-driven bench for arilla_bus_arbiter
// (2-master instance) plus a 4-master instance for wrap-around.
module tb_arilla_bus_arbiter;
  import arilla_pkg::*;

  localparam bit ERR_EN =
`ifdef ARILLA_ARB_DECODE_ERR_EN
    1'b1;
`else
    1'b0;
`endif

  localparam logic [31:0] D  = 32'hDEAD_BEEF;
  localparam logic [31:0] B  = 32'h0BAD_F00D;
  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;
  localparam logic [31:0] UN = 32'hF000_0000;
  localparam logic [31:0] W0 = 32'hAAAA_0000;
  localparam logic [31:0] W1 = 32'h1234_5678;
  localparam int NV = 15;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // Two-master DUT
  logic [1:0]  m_req2, m_we2, m_lock2, m_gnt2, m_rv2;
  logic [31:0] a0_2;
  logic [63:0] m_addr2, m_wdata2;
  logic [7:0]  m_be2;
  logic        m_err2;
  logic [31:0] m_rdata2, rdata2;

  // Four-master DUT
  logic [3:0]   m_req4, m_we4, m_lock4, m_gnt4, m_rv4;
  logic [127:0] m_addr4, m_wdata4;
  logic [15:0]  m_be4;
  logic         m_err4;
  logic [31:0]  m_rdata4;

  arilla_bus_if bus2 ();
  arilla_bus_if bus4 ();

  // Slave model: low 256 MB is mapped; read data is whatever the bench presents.
  assign bus2.hit       = (bus2.address[31:28] == 4'h0) ? 1'b1 : 1'b0;
  assign bus2.data_ptc  = rdata2;
  assign bus2.intercept = 1'b0;
  assign bus4.hit       = 1'b1;
  assign bus4.data_ptc  = D;
  assign bus4.intercept = 1'b0;

  assign m_addr2  = {A1, a0_2};
  assign m_wdata2 = {W1, W0};
  assign m_be2    = {4'b0011, 4'b1111};
  assign m_we4    = 4'b0000;
  assign m_lock4  = 4'b0000;
  assign m_addr4  = '0;
  assign m_wdata4 = '0;
  assign m_be4    = '0;

  arilla_bus_arbiter #(.NumMasters(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus_interface(bus2),
    .m_req(m_req2), .m_we(m_we2), .m_lock(m_lock2),
    .m_addr(m_addr2), .m_be(m_be2), .m_wdata(m_wdata2),
    .m_gnt(m_gnt2), .m_rsp_valid(m_rv2), .m_rsp_err(m_err2), .m_rsp_rdata(m_rdata2)
  );

  arilla_bus_arbiter #(.NumMasters(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus_interface(bus4),
    .m_req(m_req4), .m_we(m_we4), .m_lock(m_lock4),
    .m_addr(m_addr4), .m_be(m_be4), .m_wdata(m_wdata4),
    .m_gnt(m_gnt4), .m_rsp_valid(m_rv4), .m_rsp_err(m_err4), .m_rsp_rdata(m_rdata4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req, we, lock;
    logic [31:0] a0, rdata;
    logic [1:0]  e_gnt;
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic [1:0]  e_rv;
    logic        e_err;
    logic [31:0] e_rdat;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic [1:0] req, input logic [1:0] we, input logic [1:0] lock,
    input logic [31:0] a0, input logic [31:0] rdata,
    input logic [1:0] e_gnt, input logic e_rd, input logic e_wr,
    input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_be,
    input logic [1:0] e_rv, input logic e_err, input logic [31:0] e_rdat);
    vec_t v;
    v.req = req; v.we = we; v.lock = lock; v.a0 = a0; v.rdata = rdata;
    v.e_gnt = e_gnt; v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_be = e_be; v.e_rv = e_rv; v.e_err = e_err; v.e_rdat = e_rdat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; checks = 0; failures = 0;
    m_req2 = 2'b00; m_we2 = 2'b00; m_lock2 = 2'b00; a0_2 = A0; rdata2 = D;
    m_req4 = 4'b0000;

    //        req    we     lock   a0  rdata  gnt    rd    wr    addr   wdata  be       rv     err     rdat
    vecs[0]  = mk(2'b11, 2'b00, 2'b00, A0, D, 2'b01, 1'b1, 1'b0, A0,    W0,    4'b1111, 2'b00, 1'b0, 32'h0);
    vecs[1]  = mk(2'b11, 2'b00, 2'b00, A0, D, 2'b10, 1'b1, 1'b0, A1,    W1,    4'b0011, 2'b01, 1'b0, D);
    vecs[2]  = mk(2'b11, 2'b00, 2'b00, A0, D, 2'b01, 1'b1, 1'b0, A0,    W0,    4'b1111, 2'b10, 1'b0, D);
    vecs[3]  = mk(2'b10, 2'b10, 2'b00, A0, D, 2'b10, 1'b0, 1'b1, A1,    W1,    4'b0011, 2'b01, 1'b0, D);
    vecs[4]  = mk(2'b00, 2'b00, 2'b00, A0, D, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 2'b10, 1'b0, 32'h0);
    vecs[5]  = mk(2'b11, 2'b00, 2'b01, A0, D, 2'b01, 1'b1, 1'b0, A0,    W0,    4'b1111, 2'b00, 1'b0, 32'h0);
    vecs[6]  = mk(2'b10, 2'b00, 2'b01, A0, D, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 2'b01, 1'b0, D);
    vecs[7]  = mk(2'b11, 2'b00, 2'b01, A0, D, 2'b01, 1'b1, 1'b0, A0,    W0,    4'b1111, 2'b00, 1'b0, 32'h0);
    vecs[8]  = mk(2'b11, 2'b00, 2'b01, A0, D, 2'b01, 1'b1, 1'b0, A0,    W0,    4'b1111, 2'b01, 1'b0, D);
    vecs[9]  = mk(2'b11, 2'b00, 2'b00, A0, D, 2'b10, 1'b1, 1'b0, A1,    W1,    4'b0011, 2'b01, 1'b0, D);
    vecs[10] = mk(2'b01, 2'b00, 2'b00, UN, D, 2'b01, 1'b1, 1'b0, UN,    W0,    4'b1111, 2'b10, 1'b0, D);
    vecs[11] = mk(2'b00, 2'b00, 2'b00, A0, D, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 2'b01, ERR_EN,
                  ERR_EN ? 32'h0 : D);
    vecs[12] = mk(2'b01, 2'b00, 2'b00, A0, D, 2'b01, 1'b1, 1'b0, A0,    W0,    4'b1111, 2'b00, 1'b0, 32'h0);
    vecs[13] = mk(2'b01, 2'b00, 2'b00, A0, D, 2'b01, 1'b1, 1'b0, A0,    W0,    4'b1111, 2'b01, 1'b0, D);
    vecs[14] = mk(2'b00, 2'b00, 2'b00, A0, B, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 2'b01, 1'b0, B);

    // Reset state: requests present but everything held quiet.
    m_req2 = 2'b11;
    m_req4 = 4'b1001;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_gnt",   32'(m_gnt2), 32'h0);
    chk("rst_read",  32'(bus2.read), 32'h0);
    chk("rst_write", 32'(bus2.write), 32'h0);
    chk("rst_rv",    32'(m_rv2), 32'h0);
    chk("rst_err",   32'(m_err2), 32'h0);
    chk("rst_rdata", m_rdata2, 32'h0);
    chk("rst_gnt4",  32'(m_gnt4), 32'h0);
    m_req2 = 2'b00;
    m_req4 = 4'b0000;
    rst_n  = 1'b1;

    // Table-driven cycles: round robin, write ack, lock, decode error, back-to-back.
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      m_req2  = vecs[k].req;
      m_we2   = vecs[k].we;
      m_lock2 = vecs[k].lock;
      a0_2    = vecs[k].a0;
      rdata2  = vecs[k].rdata;
      #1;
      chk($sformatf("v%0d_gnt", k),   32'(m_gnt2), 32'(vecs[k].e_gnt));
      chk($sformatf("v%0d_read", k),  32'(bus2.read), 32'(vecs[k].e_rd));
      chk($sformatf("v%0d_write", k), 32'(bus2.write), 32'(vecs[k].e_wr));
      chk($sformatf("v%0d_addr", k),  bus2.address, vecs[k].e_addr);
      chk($sformatf("v%0d_wdata", k), bus2.data_ctp, vecs[k].e_wdata);
      chk($sformatf("v%0d_be", k),    32'(bus2.byte_enable), 32'(vecs[k].e_be));
      chk($sformatf("v%0d_rv", k),    32'(m_rv2), 32'(vecs[k].e_rv));
      chk($sformatf("v%0d_err", k),   32'(m_err2), 32'(vecs[k].e_err));
      chk($sformatf("v%0d_rdata", k), m_rdata2, vecs[k].e_rdat);
    end

    // Reset pulsed in the cycle after a grant drops the response.
    @(negedge clk);
    m_req2 = 2'b10; m_we2 = 2'b00; m_lock2 = 2'b00; a0_2 = A0; rdata2 = D;
    #1;
    chk("mid_gnt", 32'(m_gnt2), 32'h2);
    @(negedge clk);
    m_req2 = 2'b00;
    rst_n  = 1'b0;
    #1;
    chk("mid_rv_in_rst", 32'(m_rv2), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rv_release", 32'(m_rv2), 32'h0);
    @(negedge clk);
    m_req2 = 2'b11;
    #1;
    chk("post_rst_gnt", 32'(m_gnt2), 32'h1);
    chk("post_rst_rv",  32'(m_rv2), 32'h0);
    @(negedge clk);
    m_req2 = 2'b00;
    #1;
    chk("post_rst_rsp", 32'(m_rv2), 32'h1);
    chk("post_rst_rdata", m_rdata2, D);

    // Wrap-around on the 4-master instance: masters 3 and 0 request, last = 3.
    @(negedge clk);
    m_req4 = 4'b1001;
    #1;
    chk("wrap_gnt0", 32'(m_gnt4), 32'h1);
    @(negedge clk);
    #1;
    chk("wrap_gnt1", 32'(m_gnt4), 32'h8);
    chk("wrap_rv1",  32'(m_rv4), 32'h1);
    @(negedge clk);
    #1;
    chk("wrap_gnt2", 32'(m_gnt4), 32'h1);
    chk("wrap_rv2",  32'(m_rv4), 32'h8);
    m_req4 = 4'b0000;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
